// File: rtl/ex_iter_divider.sv
// Iterative radix-2 restoring divide/remainder unit for the EX stage (RV32M DIV/DIVU/REM/REMU).
// Holds the pipeline front via stall_req while the quotient bits are produced one per cycle.
module ex_iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  assign signed_op = ~op[0];
  assign abs_a     = (signed_op && op_a[WIDTH-1]) ? WIDTH'(-op_a) : op_a;
  assign abs_b     = (signed_op && op_b[WIDTH-1]) ? WIDTH'(-op_b) : op_b;
  assign rem_sh    = {rem_q, dvd_q[WIDTH-1]};
  assign diff      = rem_sh - {1'b0, dsr_q};

  // Reset gates stall_req so a held start cannot stall the pipe while in reset.
  assign stall_req = rst_n & ~flush &
                     (((state_q == IDLE) & start) | (state_q == CALC) | (state_q == FIX));
  assign done      = done_q;
  assign result    = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    done_d    = 1'b0;
    result_d  = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            is_rem_d  = op[1];
            neg_quo_d = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_rem_d = signed_op & op_a[WIDTH-1];
            dvd_d     = abs_a;
            dsr_d     = abs_b;
            rem_d     = '0;
            cnt_d     = CW'(WIDTH);
            if (op_b == '0) begin
              result_d = op[1] ? op_a : '1;
              done_d   = 1'b1;
              state_d  = DONE;
            end else if (signed_op && (op_a == MIN_NEG) && (&op_b)) begin
              result_d = op[1] ? '0 : MIN_NEG;
              done_d   = 1'b1;
              state_d  = DONE;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          // Quotient bits shift into the dividend register as its bits are consumed.
          dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
          rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
        FIX: begin
          if (is_rem_q) result_d = neg_rem_q ? WIDTH'(-rem_q) : rem_q;
          else          result_d = neg_quo_q ? WIDTH'(-dvd_q) : dvd_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_iter_divider.sv
// Directed and randomized self-checking bench for ex_iter_divider.
module tb_ex_iter_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall_req;
  logic        done;
  logic [31:0] result;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_iter_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall_req(stall_req), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Runs one operation from a point 1 time unit after a rising edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int cycles, output int stalls,
                       output logic stall_in_done, output logic done_after);
    op = o; op_a = a; op_b = b; start = 1'b1;
    cycles = 0; stalls = 0;
    #1;
    if (stall_req) stalls++;
    while (cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (done) break;
      if (stall_req) stalls++;
    end
    stall_in_done = stall_req;
    res = result;
    start = 1'b0;
    @(posedge clk); #1;
    done_after = done;
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; flush = 1'b0; op = 2'b01; op_a = 32'd1; op_b = 32'd1;
    #2;
    n_cmp++;
    if (done !== 1'b0 || result !== 32'd0 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: done=%b result=%h stall=%b want 0/0/0", done, result, stall_req);
    end
    start = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic();
    logic [31:0] r; int c, s; logic sd, da;
    do_op(2'b01, 32'd100, 32'd7, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'd14) begin n_fail++; $display("FAIL divu_100_7: got %0d want 14", r); end
    n_cmp++;
    if (c !== 34) begin n_fail++; $display("FAIL divu_latency: got %0d want 34", c); end
    n_cmp++;
    if (s !== 34) begin n_fail++; $display("FAIL divu_stall_cycles: got %0d want 34", s); end
    n_cmp++;
    if (sd !== 1'b0) begin n_fail++; $display("FAIL stall_in_done: got %b want 0", sd); end
    n_cmp++;
    if (da !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", da); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int c, s; logic sd, da;
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2: got %h want fffffffd", r); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2: got %h want ffffffff", r); end
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'd1) begin n_fail++; $display("FAIL rem_7_m2: got %h want 00000001", r); end
    do_op(2'b01, 32'hFFFF_FFFF, 32'd1, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_max_1: got %h want ffffffff", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int c, s; logic sd, da;
    do_op(2'b00, 32'd5, 32'd0, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'hFFFF_FFFF || c !== 1) begin
      n_fail++; $display("FAIL div_5_0: got %h in cycle %0d want ffffffff in 1", r, c);
    end
    do_op(2'b11, 32'd5, 32'd0, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'd5 || c !== 1) begin
      n_fail++; $display("FAIL remu_5_0: got %h in cycle %0d want 5 in 1", r, c);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int c, s; logic sd, da;
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'h8000_0000 || c !== 1) begin
      n_fail++; $display("FAIL div_ovf: got %h in cycle %0d want 80000000 in 1", r, c);
    end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'd0 || c !== 1) begin
      n_fail++; $display("FAIL rem_ovf: got %h in cycle %0d want 0 in 1", r, c);
    end
  endtask

  task automatic test_flush();
    logic [31:0] r; int c, s; logic sd, da; int seen;
    do_op(2'b01, 32'd100, 32'd7, r, c, s, sd, da);
    op = 2'b01; op_a = 32'd200; op_b = 32'd3; start = 1'b1;
    repeat (11) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b0;
    #1;
    n_cmp++;
    if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall_req); end
    @(posedge clk); #1; flush = 1'b0;
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses want 0", seen); end
    n_cmp++;
    if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result_kept: got %0d want 14", result); end
    do_op(2'b01, 32'd9, 32'd3, r, c, s, sd, da);
    n_cmp++;
    if (r !== 32'd3 || c !== 34) begin
      n_fail++; $display("FAIL after_flush_9_3: got %0d in cycle %0d want 3 in 34", r, c);
    end
  endtask

  task automatic test_reset_mid();
    op = 2'b00; op_a = 32'd1000; op_b = 32'd7; start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (done !== 1'b0 || result !== 32'd0 || stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: done=%b result=%h stall=%b want 0/0/0", done, result, stall_req);
    end
    start = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] r, a, b, exp; logic [1:0] o; int c, s; logic sd, da; int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 20);
        4:       b = 32'(-$urandom_range(1, 20));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      exp = ref_div(o, a, b);
      do_op(o, a, b, r, c, s, sd, da);
      n_cmp++;
      if (r !== exp || c >= 100) begin
        n_fail++; bad++;
        if (bad <= 10)
          $display("FAIL random op=%0d a=%h b=%h: got %h want %h", o, a, b, r, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
